// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared types and helpers for the byte-enabled dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int unsigned lanes_of(input int unsigned dw, input int unsigned lw);
    return dw / lw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_blk_dp_lane.sv
// ============================================================================
// Module      : ram_blk_dp_lane
// Description : One lane-wide simple dual-port array with registered read and
//               an externally resolved write-first bypass select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_blk_dp_lane #(
  parameter int unsigned LANEWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [ADDRWIDTH-1:0] waddr_i,
  input  logic [LANEWIDTH-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDRWIDTH-1:0] raddr_i,
  input  logic                 bypass_i,
  output logic [LANEWIDTH-1:0] rdata_o
);

  logic [LANEWIDTH-1:0] mem_q [2**ADDRWIDTH];
  logic [LANEWIDTH-1:0] rdata_q;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= bypass_i ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram_blk_dp_be.sv
// ============================================================================
// Module      : ram_blk_dp_be
// Description : Simple dual-port block RAM with per-lane byte enables, read
//               valid flag, write-first bypass and post-reset clear sweep.
//               Define RAM_BLK_DP_OUT_REG_EN for an extra output register
//               stage (read latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_blk_dp_be
  import ram_pkg::*;
#(
  parameter int unsigned          DATAWIDTH   = 32,
  parameter int unsigned          LANEWIDTH   = 8,
  parameter int unsigned          ADDRWIDTH   = 9,
  parameter logic [LANEWIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATAWIDTH-1:0]           wr_data,
  input  logic [ADDRWIDTH-1:0]           wr_addr,
  input  logic                           we,
  input  logic [DATAWIDTH/LANEWIDTH-1:0] wr_be,
  input  logic [ADDRWIDTH-1:0]           rd_addr,
  input  logic                           re,
  output logic [DATAWIDTH-1:0]           rd_data,
  output logic                           rd_valid,
  output logic                           busy
);

  localparam int unsigned LANES = lanes_of(DATAWIDTH, LANEWIDTH);

  if (DATAWIDTH % LANEWIDTH != 0) begin : g_param_check
    $error("ram_blk_dp_be: DATAWIDTH must be a multiple of LANEWIDTH");
  end

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                   run;
  logic                   rd_en;
  logic                   addr_match;
  logic [ADDRWIDTH-1:0]   mem_waddr;
  logic [DATAWIDTH-1:0]   rd_data_s1;
  logic                   rd_valid_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign run        = (state_q == RUN);
  assign rd_en      = run & re;
  assign addr_match = (wr_addr == rd_addr);
  assign mem_waddr  = run ? wr_addr : clr_addr_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic                 lane_we;
    logic [LANEWIDTH-1:0] lane_wdata;
    logic                 lane_bypass;

    // During the sweep every lane is forced to write the clear value.
    assign lane_we     = run ? (we & wr_be[l]) : 1'b1;
    assign lane_wdata  = run ? wr_data[l*LANEWIDTH +: LANEWIDTH] : CLEAR_VALUE;
    assign lane_bypass = run & we & wr_be[l] & addr_match;

    ram_blk_dp_lane #(
      .LANEWIDTH (LANEWIDTH),
      .ADDRWIDTH (ADDRWIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .we_i     (lane_we),
      .waddr_i  (mem_waddr),
      .wdata_i  (lane_wdata),
      .re_i     (rd_en),
      .raddr_i  (rd_addr),
      .bypass_i (lane_bypass),
      .rdata_o  (rd_data_s1[l*LANEWIDTH +: LANEWIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
    end
  end

`ifdef RAM_BLK_DP_OUT_REG_EN
  logic [DATAWIDTH-1:0] rd_data_s2_q;
  logic                 rd_valid_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_s2_q  <= '0;
      rd_valid_s2_q <= 1'b0;
    end else begin
      rd_valid_s2_q <= rd_valid_q;
      if (rd_valid_q) begin
        rd_data_s2_q <= rd_data_s1;
      end
    end
  end

  assign rd_data  = rd_data_s2_q;
  assign rd_valid = rd_valid_s2_q;
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_q;
`endif

  assign busy = ~run;

endmodule

`default_nettype wire

// File: tb/tb_ram_blk_dp_be.sv
// ============================================================================
// Module      : tb_ram_blk_dp_be
// Description : Directed self-checking bench for ram_blk_dp_be (ADDRWIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_blk_dp_be;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int AW = 4;
`ifdef RAM_BLK_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          we = 1'b0;
  logic [3:0]    wr_be = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          re = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  ram_blk_dp_be #(
    .DATAWIDTH   (DW),
    .LANEWIDTH   (LW),
    .ADDRWIDTH   (AW),
    .CLEAR_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .we       (we),
    .wr_be    (wr_be),
    .rd_addr  (rd_addr),
    .re       (re),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_addr = a; wr_data = d; wr_be = be; we = 1'b1;
    tick();
    we = 1'b0; wr_be = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    rd_addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    d = rd_data; v = rd_valid;
  endtask

  task automatic wait_sweep(input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++;
      $display("FAIL %s: busy cycles after release = %0d, required 16", name, cnt);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; logic v;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rd_data=%h rd_valid=%b busy=%b, required 0/0/1", rd_data, rd_valid, busy);
    end
    reset = 1'b0;
    wait_sweep("sweep_len");
    for (int a = 0; a < 16; a++) begin
      do_read(a[AW-1:0], d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_read[%0d]: data=%h valid=%b, required 00000000/1", a, d, v);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] d; logic v;
    do_write(4'd5, 32'hAABBCCDD, 4'b1111);
    do_write(4'd5, 32'h11223344, 4'b0101);
    do_read(4'd5, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL byte_enable: data=%h valid=%b, required aa22cc44/1", d, v);
    end
    do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd5, d, v);
    n_checks++;
    if (d !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL be_zero_noop: data=%h, required aa22cc44", d);
    end
    // With re low the output holds and valid drops.
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL hold: data=%h valid=%b, required aa22cc44/0", rd_data, rd_valid);
    end
  endtask

  task automatic test_rdw_bypass();
    logic [DW-1:0] d; logic v;
    wr_addr = 4'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b0011; we = 1'b1;
    rd_addr = 4'd7; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; wr_be = '0;
    for (int i = 1; i < LAT; i++) tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL rdw_bypass: data=%h valid=%b, required 0000beef/1", rd_data, rd_valid);
    end
    do_read(4'd7, d, v);
    n_checks++;
    if (d !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL rdw_stored: data=%h, required 0000beef", d);
    end
  endtask

  task automatic test_busy_ignore();
    logic [DW-1:0] d; logic v;
    bit seen_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_addr = 4'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111; we = 1'b1;
    rd_addr = 4'd3; re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rd_valid !== 1'b0) seen_valid = 1;
    end
    we = 1'b0; re = 1'b0; wr_be = '0;
    n_checks++;
    if (seen_valid || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: valid_seen=%0d busy=%b, required 0/0", seen_valid, busy);
    end
    do_read(4'd3, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL busy_no_write: data=%h valid=%b, required 00000000/1", d, v);
    end
  endtask

  task automatic test_mid_sweep_reset();
    logic [DW-1:0] d; logic v;
    do_write(4'd0, 32'h12345678, 4'b1111);
    // A read in flight when reset hits must be dropped.
    rd_addr = 4'd0; re = 1'b1; reset = 1'b1;
    tick();
    re = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_flush: data=%h valid=%b, required 00000000/0", rd_data, rd_valid);
    end
    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_sweep("restart_sweep_len");
    do_read(4'd0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_clear: data=%h valid=%b, required 00000000/1", d, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] expv [4];
    logic          ev;
    expv[1] = 32'h01010101; expv[2] = 32'h02020202; expv[3] = 32'h03030303;
    for (int a = 1; a <= 3; a++) do_write(a[AW-1:0], expv[a], 4'b1111);
    for (int t = 1; t <= 5; t++) begin
      if (t <= 3) begin
        re = 1'b1; rd_addr = t[AW-1:0];
      end else begin
        re = 1'b0;
      end
      tick();
      ev = (t >= LAT) && (t <= LAT + 2);
      n_checks++;
      if (rd_valid !== ev || (ev && rd_data !== expv[t-LAT+1])) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: data=%h valid=%b, required valid=%b data=%h",
                 t, rd_data, rd_valid, ev, ev ? expv[t-LAT+1] : 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_rdw_bypass();
    test_busy_ignore();
    test_mid_sweep_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
